immediate_encoder: RTL and testbench

- Inverse of the core's immediate generator: packs a 32-bit signed immediate into instruction bits [31:7] for the I, S, B and J formats.
- Merges the packed fields with the caller-supplied non-immediate bits: rd, rs1, rs2 and funct3.
- Checks that the immediate is in range and correctly aligned for its format.
- Used by the program loader and self-test sequencer to build instruction words. Valid/ready on both sides, a 2-entry output FIFO, and saturating statistics counters.

---
 rtl/immediate_encoder_if.sv | 22 ++
 rtl/immediate_encoder.sv | 127 ++++++++++++
 tb/tb_immediate_encoder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/immediate_encoder_if.sv
// rtl/immediate_encoder_if.sv - request/response bus of the immediate encoder
interface immediate_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [31:0] in_imm;
  logic [24:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_instr;
  logic [1:0]  out_err;

  modport master (
    output in_valid, in_type, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_type, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/immediate_encoder.sv
// rtl/immediate_encoder.sv - packs I/S/B/J immediates into instruction[31:7] with range/alignment check
module immediate_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  immediate_encoder_if.slave bus,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] TYPE_I = 3'b000;
  localparam logic [2:0] TYPE_S = 3'b001;
  localparam logic [2:0] TYPE_B = 3'b101;
  localparam logic [2:0] TYPE_J = 3'b110;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_TYPE  = 2'b11;

  logic [24:0] enc_instr;
  logic [1:0]  enc_err;
  logic        fits_12;
  logic        fits_13;
  logic        fits_21;

  // a value fits N signed bits when all bits from N-1 upward agree with the sign
  assign fits_12 = (&bus.in_imm[31:11]) | ~(|bus.in_imm[31:11]);
  assign fits_13 = (&bus.in_imm[31:12]) | ~(|bus.in_imm[31:12]);
  assign fits_21 = (&bus.in_imm[31:20]) | ~(|bus.in_imm[31:20]);

  // scatter the immediate over the base word; failures leave the base untouched
  always_comb begin
    enc_instr = bus.in_base;
    enc_err   = ERR_OK;
    case (bus.in_type)
      TYPE_I: begin
        if (!fits_12) enc_err = ERR_RANGE;
        else enc_instr[24:13] = bus.in_imm[11:0];
      end
      TYPE_S: begin
        if (!fits_12) enc_err = ERR_RANGE;
        else begin
          enc_instr[24:18] = bus.in_imm[11:5];
          enc_instr[4:0]   = bus.in_imm[4:0];
        end
      end
      TYPE_B: begin
        if (bus.in_imm[0]) enc_err = ERR_ALIGN;
        else if (!fits_13) enc_err = ERR_RANGE;
        else begin
          enc_instr[24]    = bus.in_imm[12];
          enc_instr[0]     = bus.in_imm[11];
          enc_instr[23:18] = bus.in_imm[10:5];
          enc_instr[4:1]   = bus.in_imm[4:1];
        end
      end
      TYPE_J: begin
        if (bus.in_imm[0]) enc_err = ERR_ALIGN;
        else if (!fits_21) enc_err = ERR_RANGE;
        else begin
          enc_instr[24]    = bus.in_imm[20];
          enc_instr[12:5]  = bus.in_imm[19:12];
          enc_instr[13]    = bus.in_imm[11];
          enc_instr[23:14] = bus.in_imm[10:1];
        end
      end
      default: enc_err = ERR_TYPE;
    endcase
  end

  logic [26:0] mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  assign bus.in_ready  = (count < 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_instr = mem[rd_ptr][26:2];
  assign bus.out_err   = mem[rd_ptr][1:0];

  // two-entry result FIFO; simultaneous push and pop keeps occupancy and order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {enc_instr, enc_err};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // saturating statistics; clr wins over a same-edge increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (clr) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (push) begin
      if (enc_err == ERR_OK) begin
        if (enc_count != {CNT_W{1'b1}}) enc_count <= enc_count + 1'b1;
      end else begin
        if (err_count != {CNT_W{1'b1}}) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_immediate_encoder.sv
// tb/tb_immediate_encoder.sv - directed self-checking bench for immediate_encoder
module tb_immediate_encoder;
  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        clr2;
  logic [15:0] enc_count;
  logic [15:0] err_count;
  logic [3:0]  enc_count2;
  logic [3:0]  err_count2;
  int          checks;
  int          errors;

  immediate_encoder_if bus ();
  immediate_encoder_if bus2 ();

  immediate_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus),
    .enc_count(enc_count), .err_count(err_count)
  );

  immediate_encoder #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .clr(clr2), .bus(bus2),
    .enc_count(enc_count2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] t, input logic [31:0] imm, input logic [24:0] base);
    int n;
    n = 0;
    bus.in_type  = t;
    bus.in_imm   = imm;
    bus.in_base  = base;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) check("push_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [24:0] instr, input logic [1:0] err);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) check({tag, "_timeout"}, 32'd0, 32'd1);
    check({tag, "_instr"}, 32'(bus.out_instr), 32'(instr));
    check({tag, "_err"}, 32'(bus.out_err), 32'(err));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  logic [24:0] got_q [$];
  logic        c_taken;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    clr = 1'b0;
    clr2 = 1'b0;
    bus.in_valid = 1'b0; bus.in_type = 3'b000; bus.in_imm = '0; bus.in_base = '0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_type = 3'b011; bus2.in_imm = '0; bus2.in_base = '0; bus2.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_instr", 32'(bus.out_instr), 32'd0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    check("rst_enc_count", 32'(enc_count), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    push(3'b000, 32'hFFFF_FFFF, 25'h0);
    check("i_latency_valid", 32'(bus.out_valid), 32'd1);
    check("i_enc_count", 32'(enc_count), 32'd1);
    pop_expect("i_neg1", 25'h1FFE000, 2'b00);

    push(3'b001, 32'h0000_07FF, 25'h0001FE0);
    pop_expect("s_max", 25'h0FC1FFF, 2'b00);
    push(3'b101, 32'h0000_0800, 25'h0);
    pop_expect("b_bit11", 25'h0000001, 2'b00);
    push(3'b101, 32'h0000_0003, 25'h0000123);
    pop_expect("b_misalign", 25'h0000123, 2'b10);
    check("b_err_count", 32'(err_count), 32'd1);
    push(3'b101, 32'h0000_1001, 25'h0000055);
    pop_expect("b_align_over_range", 25'h0000055, 2'b10);
    push(3'b110, 32'hFFF0_0000, 25'h0);
    pop_expect("j_min", 25'h1000000, 2'b00);
    push(3'b110, 32'h0010_0000, 25'h00000AA);
    pop_expect("j_range", 25'h00000AA, 2'b01);
    push(3'b011, 32'h0000_0003, 25'h0000F0F);
    pop_expect("unsupported", 25'h0000F0F, 2'b11);
    push(3'b000, 32'h0000_0800, 25'h0);
    pop_expect("i_range", 25'h0, 2'b01);
    check("tally_enc", 32'(enc_count), 32'd4);
    check("tally_err", 32'(err_count), 32'd5);

    // three back-to-back requests against a stalled consumer
    bus.out_ready = 1'b0;
    bus.in_type = 3'b000; bus.in_base = 25'h0; bus.in_imm = 32'd1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_imm = 32'd2;
    @(posedge clk); #1;
    check("fifo_full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_imm = 32'd3;
    @(posedge clk); #1;
    check("fifo_held_in_ready", 32'(bus.in_ready), 32'd0);
    check("fifo_head_stable", 32'(bus.out_instr), 32'h0002000);
    bus.out_ready = 1'b1;
    c_taken = 1'b0;
    for (int i = 0; i < 12 && got_q.size() < 4; i++) begin
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) c_taken = 1'b1;
      if (bus.out_valid) got_q.push_back(bus.out_instr);
      @(posedge clk); #1;
      if (c_taken) bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b0;
    check("fifo_count", 32'(got_q.size()), 32'd3);
    if (got_q.size() >= 3) begin
      check("fifo_order0", 32'(got_q[0]), 32'h0002000);
      check("fifo_order1", 32'(got_q[1]), 32'h0004000);
      check("fifo_order2", 32'(got_q[2]), 32'h0006000);
    end
    check("fifo_enc_count", 32'(enc_count), 32'd7);

    // asynchronous reset with two entries pending
    push(3'b000, 32'd5, 25'h0);
    push(3'b000, 32'd6, 25'h0);
    check("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_enc_count", 32'(enc_count), 32'd0);
    check("arst_err_count", 32'(err_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    push(3'b110, 32'hFFF0_0000, 25'h0);
    pop_expect("post_rst_j", 25'h1000000, 2'b00);
    check("post_rst_enc_count", 32'(enc_count), 32'd1);

    // drive enc_count to saturation
    bus.in_type = 3'b000; bus.in_imm = 32'd0; bus.in_base = 25'h0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    check("enc_saturate", 32'(enc_count), 32'h0000FFFF);
    check("sat_err_count", 32'(err_count), 32'd0);
    clr = 1'b1;
    @(posedge clk); #1;
    check("clr_beats_inc", 32'(enc_count), 32'd0);
    clr = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("drained_out_valid", 32'(bus.out_valid), 32'd0);

    // err_count saturation on the narrow-counter instance
    bus2.in_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("err_saturate", 32'(err_count2), 32'h0000000F);
    check("err_sat_enc", 32'(enc_count2), 32'd0);
    clr2 = 1'b1;
    @(posedge clk); #1;
    check("clr_err_beats_inc", 32'(err_count2), 32'd0);
    clr2 = 1'b0;
    bus2.in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
